// File: rtl/cmd_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : cmd_stream_encoder
// Purpose  : Host-side transmitter for the byte-serial register-write command
//            stream. Parallel (reg, value) write requests are buffered in a
//            small FIFO. Each request is sent as two bytes, one per clock:
//            the opcode byte {reg, OPCODE}, then the data byte. IDLE_BYTE is
//            driven whenever no command is in flight.
// Ports    : clk         - clock, all state updates on posedge
//            rst_n       - synchronous active-low reset
//            req_valid   - write request present
//            req_ready   - FIFO can accept a request (= !full, combinational)
//            req_reg     - destination register index
//            req_data    - value to write
//            cmd_byte    - serialized command bus (registered)
//            cmd_valid   - cmd_byte carries an opcode or data byte (registered)
//            busy        - FIFO non-empty or a command is in flight
//            fifo_level  - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module cmd_stream_encoder #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         GAP_CYCLES = 0,
  parameter logic [3:0] OPCODE     = 4'b0001,
  parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_reg,
  input  logic [7:0]                    req_data,
  output logic [7:0]                    cmd_byte,
  output logic                          cmd_valid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int           AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]   GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // FIFO storage: each entry is {reg[3:0], data[7:0]}
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [11:0]   head;

  state_t        state;
  logic [3:0]    gap_cnt;
  logic [7:0]    cur_data;   // data byte of the in-flight command

  assign full      = (fifo_level == FULL_LVL);
  assign empty     = (fifo_level == '0);
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr];
  assign busy      = !empty || (state != S_IDLE);

  // Pop decision mirrors the FSM transitions that start a new command.
  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE:  pop = !empty;
      S_DATA:  pop = (GAP_CYCLES == 0) && !empty;
      S_GAP:   pop = (gap_cnt == 4'd1) && !empty;
      default: pop = 1'b0;
    endcase
  end

  // Storage carries no reset; gating the write on rst_n keeps requests
  // presented during reset from landing anywhere.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= {req_reg, req_data};
    end
  end

  // Pointers are AW bits wide and wrap naturally; the extra level bit
  // separates full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Serializer. The state names what cmd_byte shows in the same cycle, so
  // each transition also loads the byte for the state being entered. On a
  // pop the opcode byte is built straight from the FIFO head and the data
  // byte is latched so later FIFO traffic cannot disturb the command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      cur_data  <= '0;
      cmd_byte  <= IDLE_BYTE;
      cmd_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_data  <= head[7:0];
            cmd_byte  <= {head[11:8], OPCODE};
            cmd_valid <= 1'b1;
            state     <= S_OP;
          end else begin
            cmd_byte  <= IDLE_BYTE;
            cmd_valid <= 1'b0;
          end
        end
        S_OP: begin
          cmd_byte  <= cur_data;
          cmd_valid <= 1'b1;
          state     <= S_DATA;
        end
        S_DATA: begin
          if (GAP_CYCLES > 0) begin
            gap_cnt   <= GAP_LOAD;
            cmd_byte  <= IDLE_BYTE;
            cmd_valid <= 1'b0;
            state     <= S_GAP;
          end else if (pop) begin
            cur_data  <= head[7:0];
            cmd_byte  <= {head[11:8], OPCODE};
            cmd_valid <= 1'b1;
            state     <= S_OP;
          end else begin
            cmd_byte  <= IDLE_BYTE;
            cmd_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd1) begin
            if (pop) begin
              cur_data  <= head[7:0];
              cmd_byte  <= {head[11:8], OPCODE};
              cmd_valid <= 1'b1;
              state     <= S_OP;
            end else begin
              cmd_byte  <= IDLE_BYTE;
              cmd_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end else begin
            gap_cnt   <= gap_cnt - 1'b1;
            cmd_byte  <= IDLE_BYTE;
            cmd_valid <= 1'b0;
          end
        end
        default: begin
          cmd_byte  <= IDLE_BYTE;
          cmd_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
